mc_bin_req_parser: RTL and testbench
====================================

Name: mc_bin_req_parser

Overview:
- Sits directly downstream of header_handler on its toApp AXI-Stream output, feeding the memcached application core.
- Consumes each packet (network headers already stripped) and parses the fixed 24-byte memcached binary-protocol request header, which arrives as exactly 3 beats of 64 bits.
- Emits one metadata record per packet on a valid/ready side channel, then forwards the body (extras, key, value) unchanged on an AXI-Stream master.
- Drops malformed packets and counts them.

Parameters:
- REQ_MAGIC, 8'h80, required value of header byte 0; any other value drops the packet.
- CNT_W, 32, width of the statistics counters.

Ports:
- apclk  in  1  clock
- apresetn  in  1  reset
- s_axis_tdata  in  64  packet data; byte n is at tdata[8n+7:8n]
- s_axis_tkeep  in  8  byte enables
- s_axis_tuser  in  64  per-packet sideband; sampled on header beat 0
- s_axis_tlast  in  1  end of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- meta_opcode  out  8  header byte 1
- meta_keylen  out  16  bytes 2-3, big-endian
- meta_extlen  out  8  byte 4
- meta_bodylen  out  32  bytes 8-11, big-endian
- meta_opaque  out  32  bytes 12-15, passed through as raw bytes
- meta_user  out  64  captured tuser
- meta_nobody  out  1  set when the packet ended on header beat 2
- meta_valid  out  1  metadata valid
- meta_ready  in  1  metadata accepted
- m_axis_tdata  out  64  body data
- m_axis_tkeep  out  8  body byte enables
- m_axis_tlast  out  1  body end of packet
- m_axis_tvalid  out  1  body valid
- m_axis_tready  in  1  body ready
- pkt_cnt  out  CNT_W  packets whose metadata was accepted
- err_cnt  out  CNT_W  packets dropped
- len_err_cnt  out  CNT_W  bodies whose byte count differed from bodylen

Behaviour:
- Clock and reset: single clock apclk; apresetn is asynchronous, active-low.
- Reset values:
  - all valids and s_axis_tready are 0;
  - all meta fields are 0;
  - all counters are 0;
  - state is HDR0.
- Reset asserted mid-packet aborts the packet immediately. After release, the block resumes in HDR0 and treats the next beat as a header beat. The remainder of the interrupted packet is the source's problem.
- State HDR0:
  - s_axis_tready=1.
  - On handshake, capture bytes 0-7 and tuser.
  - If byte0!=REQ_MAGIC or tlast=1, go to DROP (or stay in HDR0 if tlast=1) and increment err_cnt.
  - Otherwise go to HDR1.
- State HDR1:
  - s_axis_tready=1.
  - Capture bytes 8-15.
  - If tlast=1, go to HDR0 and increment err_cnt. Otherwise go to HDR2.
- State HDR2:
  - s_axis_tready=1.
  - Bytes 16-23 (CAS) are discarded.
  - Go to META; meta_nobody is set to that beat's tlast.
- State META:
  - meta_valid=1, s_axis_tready=0.
  - On meta_valid&meta_ready, increment pkt_cnt.
  - Next state is HDR0 if meta_nobody is set, otherwise BODY.
  - Meta fields are held stable while meta_valid=1.
- State BODY:
  - Zero-latency combinational pass-through: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready; tdata, tkeep and tlast pass directly.
  - A 32-bit byte counter accumulates popcount(tkeep) per handshake.
  - On the handshake carrying tlast: if total != meta_bodylen, increment len_err_cnt. Go to HDR0 either way; the body is forwarded unmodified regardless.
- State DROP:
  - s_axis_tready=1, nothing is output.
  - Go to HDR0 on a tlast handshake.
- Other rules:
  - m_axis_tvalid=0 outside BODY.
  - Counters wrap at 2^CNT_W.
  - Header beats ignore tkeep; all 8 bytes are taken as valid.
  - The byte counter resets to 0 on entry to BODY.
  - meta_nobody=1 with meta_bodylen!=0 increments len_err_cnt when the metadata is accepted.

Test Plan:
- GET request: magic 80, opcode 00, keylen 0005, extlen 00, bodylen 00000005, opaque DEADBEEF, 1 body beat with tkeep=1F and tlast.
  - One meta record with opcode=00, keylen=5, bodylen=5, opaque=DEADBEEF.
  - One body beat with tkeep=1F and tlast.
  - pkt_cnt=1.
- Bad magic: byte0=81, 5-beat packet.
  - No meta, no body.
  - All 5 beats accepted.
  - err_cnt=1; the next valid packet parses normally.
- Short packet: tlast on header beat 1 -> err_cnt=1, state back in HDR0, no meta.
- Backpressure: meta_ready held low 10 cycles, then m_axis_tready toggled 1/0 every cycle over a 4-beat body.
  - s_axis_tready stays 0 during META.
  - Body beats come out in order with none lost or duplicated.
- Header-only packet (tlast on beat 2, bodylen 0) -> meta_nobody=1, no body output, len_err_cnt=0. Repeat with bodylen=8 -> len_err_cnt=1.
- Length mismatch: bodylen=16, body of 2 beats with tkeep FF,0F.
  - len_err_cnt=1, body forwarded intact.
  - Assert apresetn mid-body: all outputs and counters return to 0 asynchronously.

Source files
------------

// File: rtl/mc_bin_req_parser.sv
// Memcached binary-protocol request header parser: strips the 24-byte header
// into a metadata record, forwards the body, and keeps drop/length statistics.
module mc_bin_req_parser #(
  parameter logic [7:0]  REQ_MAGIC = 8'h80,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             apclk,
  input  logic             apresetn,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic [63:0]      s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       meta_opcode,
  output logic [15:0]      meta_keylen,
  output logic [7:0]       meta_extlen,
  output logic [31:0]      meta_bodylen,
  output logic [31:0]      meta_opaque,
  output logic [63:0]      meta_user,
  output logic             meta_nobody,
  output logic             meta_valid,
  input  logic             meta_ready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] len_err_cnt
);

  typedef enum logic [2:0] {HDR0, HDR1, HDR2, META, BODY, DROP} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             run_q;
  logic [7:0]       opcode_q, opcode_d, extlen_q, extlen_d;
  logic [15:0]      keylen_q, keylen_d;
  logic [31:0]      bodylen_q, bodylen_d, opaque_q, opaque_d;
  logic [31:0]      bcnt_q, bcnt_d, body_total;
  logic [63:0]      user_q, user_d;
  logic             nobody_q, nobody_d;
  logic [CNT_W-1:0] pkt_q, pkt_d, err_q, err_d, lerr_q, lerr_d;

  function automatic logic [3:0] popcnt8(input logic [7:0] k);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, k[i]};
    return n;
  endfunction

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    keylen_d  = keylen_q;
    extlen_d  = extlen_q;
    bodylen_d = bodylen_q;
    opaque_d  = opaque_q;
    user_d    = user_q;
    nobody_d  = nobody_q;
    bcnt_d    = bcnt_q;
    pkt_d     = pkt_q;
    err_d     = err_q;
    lerr_d    = lerr_q;
    s_axis_tready = 1'b0;
    meta_valid    = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    body_total    = bcnt_q + {28'd0, popcnt8(s_axis_tkeep)};
    case (state_q)
      HDR0: begin
        // run_q keeps tready low until the first clock after reset release
        s_axis_tready = run_q;
        if (run_q && s_axis_tvalid) begin
          opcode_d = s_axis_tdata[15:8];
          keylen_d = {s_axis_tdata[23:16], s_axis_tdata[31:24]};
          extlen_d = s_axis_tdata[39:32];
          user_d   = s_axis_tuser;
          if (s_axis_tdata[7:0] != REQ_MAGIC || s_axis_tlast) begin
            err_d   = err_q + CNT_ONE;
            state_d = s_axis_tlast ? HDR0 : DROP;
          end else begin
            state_d = HDR1;
          end
        end
      end
      HDR1: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          bodylen_d = {s_axis_tdata[7:0], s_axis_tdata[15:8],
                       s_axis_tdata[23:16], s_axis_tdata[31:24]};
          opaque_d  = s_axis_tdata[63:32];
          if (s_axis_tlast) begin
            err_d   = err_q + CNT_ONE;
            state_d = HDR0;
          end else begin
            state_d = HDR2;
          end
        end
      end
      HDR2: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          nobody_d = s_axis_tlast;
          state_d  = META;
        end
      end
      META: begin
        meta_valid = 1'b1;
        if (meta_ready) begin
          pkt_d  = pkt_q + CNT_ONE;
          bcnt_d = '0;
          if (nobody_q) begin
            if (bodylen_q != '0) lerr_d = lerr_q + CNT_ONE;
            state_d = HDR0;
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tlast  = s_axis_tlast;
        if (s_axis_tvalid && m_axis_tready) begin
          bcnt_d = body_total;
          if (s_axis_tlast) begin
            if (body_total != bodylen_q) lerr_d = lerr_q + CNT_ONE;
            state_d = HDR0;
          end
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = HDR0;
      end
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge apclk or negedge apresetn) begin
    if (!apresetn) begin
      state_q   <= HDR0;
      run_q     <= 1'b0;
      opcode_q  <= '0;
      keylen_q  <= '0;
      extlen_q  <= '0;
      bodylen_q <= '0;
      opaque_q  <= '0;
      user_q    <= '0;
      nobody_q  <= 1'b0;
      bcnt_q    <= '0;
      pkt_q     <= '0;
      err_q     <= '0;
      lerr_q    <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      opcode_q  <= opcode_d;
      keylen_q  <= keylen_d;
      extlen_q  <= extlen_d;
      bodylen_q <= bodylen_d;
      opaque_q  <= opaque_d;
      user_q    <= user_d;
      nobody_q  <= nobody_d;
      bcnt_q    <= bcnt_d;
      pkt_q     <= pkt_d;
      err_q     <= err_d;
      lerr_q    <= lerr_d;
    end
  end

  assign meta_opcode  = opcode_q;
  assign meta_keylen  = keylen_q;
  assign meta_extlen  = extlen_q;
  assign meta_bodylen = bodylen_q;
  assign meta_opaque  = opaque_q;
  assign meta_user    = user_q;
  assign meta_nobody  = nobody_q;
  assign pkt_cnt      = pkt_q;
  assign err_cnt      = err_q;
  assign len_err_cnt  = lerr_q;

endmodule

// File: tb/tb_mc_bin_req_parser.sv
// Bench for mc_bin_req_parser: packet table plus scoreboard queues for the
// metadata and body channels, with backpressure and mid-body reset sequences.
module tb_mc_bin_req_parser;

  logic        apclk = 1'b0;
  logic        apresetn;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic [63:0] s_axis_tuser;
  logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [7:0]  meta_opcode, meta_extlen;
  logic [15:0] meta_keylen;
  logic [31:0] meta_bodylen, meta_opaque;
  logic [63:0] meta_user;
  logic        meta_nobody, meta_valid, meta_ready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [31:0] pkt_cnt, err_cnt, len_err_cnt;

  mc_bin_req_parser #(.REQ_MAGIC(8'h80), .CNT_W(32)) dut (
    .apclk(apclk), .apresetn(apresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .meta_opcode(meta_opcode), .meta_keylen(meta_keylen), .meta_extlen(meta_extlen),
    .meta_bodylen(meta_bodylen), .meta_opaque(meta_opaque), .meta_user(meta_user),
    .meta_nobody(meta_nobody), .meta_valid(meta_valid), .meta_ready(meta_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .len_err_cnt(len_err_cnt)
  );

  always #5 apclk = ~apclk;

  // hdr_last: header beat index carrying tlast (0..2), or 3 for a full header plus body
  typedef struct {
    logic [7:0]  magic, opcode;
    logic [15:0] keylen;
    logic [7:0]  extlen;
    logic [31:0] bodylen, opaque;
    int          hdr_last;
    int          nbody;
    logic [7:0]  keep_last;
    bit          exp_meta;
    int          exp_err;
    int          exp_len;
  } vec_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] keylen;
    logic [7:0]  extlen;
    logic [31:0] bodylen, opaque;
    logic [63:0] user;
    logic        nobody;
  } meta_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  meta_t       mq[$];
  beat_t       bq[$];
  vec_t        tbl[9];
  logic [63:0] hb[3];
  logic [63:0] bb[8];
  logic [7:0]  bk[8];
  logic [63:0] pu;
  int          errors = 0, checks = 0;
  int          exp_pkt = 0, exp_err = 0, exp_len = 0;
  bit          toggle_en;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [63:0] u);
    bit ok;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge apclk);
      ok = s_axis_tready;
      @(posedge apclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    chk("beat_accepted", 64'(ok), 64'd1);
  endtask

  task automatic prep_pkt(input vec_t v, input int npush);
    meta_t em;
    beat_t eb;
    pu    = {$urandom, $urandom};
    hb[0] = {16'($urandom), 8'h00, v.extlen, v.keylen[7:0], v.keylen[15:8], v.opcode, v.magic};
    hb[1] = {v.opaque, v.bodylen[7:0], v.bodylen[15:8], v.bodylen[23:16], v.bodylen[31:24]};
    hb[2] = {$urandom, $urandom};
    for (int b = 0; b < v.nbody; b++) begin
      bb[b] = {$urandom, $urandom};
      bk[b] = (b == v.nbody - 1) ? v.keep_last : 8'hFF;
    end
    if (v.exp_meta) begin
      em.opcode = v.opcode; em.keylen = v.keylen; em.extlen = v.extlen;
      em.bodylen = v.bodylen; em.opaque = v.opaque; em.user = pu;
      em.nobody = (v.hdr_last == 2);
      mq.push_back(em);
      if (v.hdr_last == 3)
        for (int b = 0; b < npush; b++) begin
          eb.data = bb[b]; eb.keep = bk[b]; eb.last = (b == v.nbody - 1);
          bq.push_back(eb);
        end
    end
  endtask

  // header beats carry random tkeep: the parser must ignore it
  task automatic send_hdr(input vec_t v);
    int n;
    n = (v.hdr_last > 2) ? 2 : v.hdr_last;
    for (int i = 0; i <= n; i++)
      send_beat(hb[i], 8'($urandom), (i == v.hdr_last), (i == 0) ? pu : 64'h0);
  endtask

  task automatic send_body(input vec_t v, input int n);
    for (int b = 0; b < n; b++)
      send_beat(bb[b], bk[b], (b == v.nbody - 1), 64'h0);
  endtask

  task automatic drain_and_check(input string tag);
    repeat (4) @(posedge apclk);
    #1;
    chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    chk({tag, "_len_err_cnt"}, 64'(len_err_cnt), 64'(exp_len));
    chk({tag, "_idle"}, {61'd0, s_axis_tready, meta_valid, m_axis_tvalid}, 64'b100);
  endtask

  initial begin
    vec_t bp, rv;
    meta_t got_m, exp_m;
    beat_t got_b, exp_b;
    int nt;

    tbl[0] = '{8'h80, 8'h00, 16'h0005, 8'h00, 32'd5,  32'hDEADBEEF, 3, 1, 8'h1F, 1'b1, 0, 0};
    tbl[1] = '{8'h81, 8'h00, 16'h0005, 8'h00, 32'd5,  32'h00000000, 3, 2, 8'hFF, 1'b0, 1, 0};
    tbl[2] = '{8'h80, 8'h01, 16'h0003, 8'h08, 32'd19, 32'h11223344, 3, 3, 8'h07, 1'b1, 0, 0};
    tbl[3] = '{8'h80, 8'h00, 16'h0005, 8'h00, 32'd5,  32'h00000000, 1, 0, 8'hFF, 1'b0, 1, 0};
    tbl[4] = '{8'h80, 8'h0A, 16'h0000, 8'h00, 32'd0,  32'h55AA55AA, 2, 0, 8'hFF, 1'b1, 0, 0};
    tbl[5] = '{8'h80, 8'h0A, 16'h0000, 8'h00, 32'd8,  32'hA5A5A5A5, 2, 0, 8'hFF, 1'b1, 0, 1};
    tbl[6] = '{8'h80, 8'h00, 16'h0004, 8'h04, 32'd16, 32'h01020304, 3, 2, 8'h0F, 1'b1, 0, 1};
    tbl[7] = '{8'h80, 8'h00, 16'h0000, 8'h00, 32'd0,  32'h00000000, 0, 0, 8'hFF, 1'b0, 1, 0};
    tbl[8] = '{8'h80, 8'h00, 16'h0008, 8'h10, 32'd24, 32'hFEEDFACE, 3, 3, 8'hFF, 1'b1, 0, 0};
    bp     = '{8'h80, 8'h01, 16'h0003, 8'h08, 32'd32, 32'h12345678, 3, 4, 8'hFF, 1'b1, 0, 0};
    rv     = '{8'h80, 8'h01, 16'h0004, 8'h00, 32'd16, 32'hCAFEF00D, 3, 2, 8'h0F, 1'b1, 0, 0};

    apresetn = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    meta_ready = 1'b1; m_axis_tready = 1'b1;
    #1;
    chk("rst_valids_ready", {61'd0, s_axis_tready, meta_valid, m_axis_tvalid}, 64'd0);
    chk("rst_counters", {pkt_cnt | err_cnt | len_err_cnt, 32'd0}, 64'd0);
    chk("rst_meta", meta_user | {meta_opaque, meta_bodylen}, 64'd0);
    repeat (3) @(posedge apclk);
    #1 apresetn = 1'b1;

    fork
      forever begin
        @(negedge apclk);
        if (apresetn) begin
          if (meta_valid && meta_ready) begin
            got_m = {meta_opcode, meta_keylen, meta_extlen, meta_bodylen,
                     meta_opaque, meta_user, meta_nobody};
            checks++;
            if (mq.size() == 0) begin
              errors++;
              $display("FAIL meta_unexpected: got %h expected no record", got_m);
            end else begin
              exp_m = mq.pop_front();
              if (got_m !== exp_m) begin
                errors++;
                $display("FAIL meta_record: got %h expected %h", got_m, exp_m);
              end
            end
          end
          if (m_axis_tvalid && m_axis_tready) begin
            got_b = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            checks++;
            if (bq.size() == 0) begin
              errors++;
              $display("FAIL body_unexpected: got %h expected no beat", got_b);
            end else begin
              exp_b = bq.pop_front();
              if (got_b !== exp_b) begin
                errors++;
                $display("FAIL body_beat: got %h expected %h", got_b, exp_b);
              end
            end
          end
        end
      end
    join_none

    for (int i = 0; i < 9; i++) begin
      prep_pkt(tbl[i], tbl[i].nbody);
      send_hdr(tbl[i]);
      if (tbl[i].hdr_last == 3) send_body(tbl[i], tbl[i].nbody);
      exp_pkt += int'(tbl[i].exp_meta);
      exp_err += tbl[i].exp_err;
      exp_len += tbl[i].exp_len;
      drain_and_check($sformatf("vec%0d", i));
    end

    // metadata stall, then a body under alternating m_axis_tready
    meta_ready = 1'b0;
    prep_pkt(bp, 4);
    send_hdr(bp);
    repeat (10) begin
      @(negedge apclk);
      chk("meta_hold_valid", 64'(meta_valid), 64'd1);
      chk("meta_hold_tready", 64'(s_axis_tready), 64'd0);
    end
    @(posedge apclk);
    #1 meta_ready = 1'b1;
    toggle_en = 1'b1;
    fork
      begin
        send_body(bp, 4);
        toggle_en = 1'b0;
      end
      begin
        nt = 0;
        while (toggle_en && nt < 400) begin
          @(posedge apclk);
          #1 m_axis_tready = ~m_axis_tready;
          nt++;
        end
      end
    join
    m_axis_tready = 1'b1;
    exp_pkt++;
    drain_and_check("bp");
    chk("bp_body_drained", 64'(bq.size()), 64'd0);

    // reset asserted while a body beat is being presented
    prep_pkt(rv, 1);
    send_hdr(rv);
    send_body(rv, 1);
    s_axis_tdata = bb[1]; s_axis_tkeep = bk[1]; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    #1;
    chk("pre_rst_mvalid", 64'(m_axis_tvalid), 64'd1);
    apresetn = 1'b0;
    #1;
    chk("arst_valids_ready", {61'd0, s_axis_tready, meta_valid, m_axis_tvalid}, 64'd0);
    chk("arst_counters", {pkt_cnt | err_cnt | len_err_cnt, 32'd0}, 64'd0);
    chk("arst_meta", meta_user | {meta_opaque, meta_bodylen} |
        {39'd0, meta_opcode, meta_keylen, meta_nobody}, 64'd0);
    chk("arst_mdata", m_axis_tdata | {56'd0, m_axis_tkeep}, 64'd0);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (2) @(posedge apclk);
    #1 apresetn = 1'b1;
    exp_pkt = 0; exp_err = 0; exp_len = 0;

    prep_pkt(tbl[0], tbl[0].nbody);
    send_hdr(tbl[0]);
    send_body(tbl[0], tbl[0].nbody);
    exp_pkt = 1;
    drain_and_check("post_rst");
    chk("meta_queue_empty", 64'(mq.size()), 64'd0);
    chk("body_queue_empty", 64'(bq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
